// File: rtl/ch3_pkg.sv
// ch3_pkg: shared types and constants for the channel-3 (wave) sequencer.
//   ch3_state_e      : channel on/off state
//   ch3_vol_e        : NR32 output level code
//   CH3_TIMER_MAX    : frequency timer value that triggers a reload/fetch
//   CH3_LEN_FULL     : length load value meaning "256 ticks"
//   ch3_vol_shift()  : applies the NR32 level code to a 4-bit sample
package ch3_pkg;

    localparam int CH3_TIMER_MAX = 2047;
    localparam int CH3_LEN_FULL  = 256;

    typedef enum logic {
        CH3_OFF = 1'b0,
        CH3_RUN = 1'b1
    } ch3_state_e;

    typedef enum logic [1:0] {
        CH3_VOL_MUTE    = 2'b00,
        CH3_VOL_FULL    = 2'b01,
        CH3_VOL_HALF    = 2'b10,
        CH3_VOL_QUARTER = 2'b11
    } ch3_vol_e;

    function automatic logic [3:0] ch3_vol_shift(input logic [3:0] smp, input logic [1:0] code);
        logic [3:0] res;
        case (ch3_vol_e'(code))
            CH3_VOL_MUTE:    res = 4'd0;
            CH3_VOL_FULL:    res = smp;
            CH3_VOL_HALF:    res = smp >> 1;
            CH3_VOL_QUARTER: res = smp >> 2;
            default:         res = 4'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ch3_len_ctr.sv
// ch3_len_ctr: channel-3 length counter (0..256 ticks remaining).
//   cery_2mhz  in  : APU 2 MHz clock
//   napu_reset in  : asynchronous active-low reset
//   len_wr     in  : NR31 write strobe, loads 256 - len_data
//   len_data   in  : NR31 value
//   trig       in  : trigger strobe, reloads 256 only when the counter is empty
//   len_tick   in  : 256 Hz frame-sequencer strobe
//   len_en     in  : NR34 bit 6, enables decrementing
//   len_expire out : combinational pulse in the cycle a tick takes the count 1 -> 0
module ch3_len_ctr
    import ch3_pkg::*;
#(
    parameter int LEN_W = 9
) (
    input  logic       cery_2mhz,
    input  logic       napu_reset,
    input  logic       len_wr,
    input  logic [7:0] len_data,
    input  logic       trig,
    input  logic       len_tick,
    input  logic       len_en,
    output logic       len_expire
);

    logic [LEN_W-1:0] len_rem;
    logic             tick_ok;

    // A write or trigger in the same cycle swallows the tick.
    assign tick_ok    = len_tick && len_en && !len_wr && !trig && (len_rem != '0);
    assign len_expire = tick_ok && (len_rem == LEN_W'(1));

    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            len_rem <= '0;
        end else if (len_wr) begin
            len_rem <= LEN_W'(CH3_LEN_FULL) - LEN_W'(len_data);
        end else if (trig) begin
            if (len_rem == '0) len_rem <= LEN_W'(CH3_LEN_FULL);
        end else if (tick_ok) begin
            len_rem <= len_rem - 1'b1;
        end
    end

endmodule

// File: rtl/ch3_wave_seq.sv
// ch3_wave_seq: channel-3 sequencer and wave-RAM arbiter.
// Runs the frequency timer, sample position and on/off state, fetches
// wave-RAM bytes, shares the single wave-RAM port with the CPU and drives
// the volume-shifted sample to the DAC.
//
// Ports:
//   cery_2mhz, napu_reset        : clock, async active-low reset
//   dac_en, len_wr, len_data,
//   len_en, freq, trig, vol_code : decoded NR30-NR34 fields / strobes
//   len_tick                     : 256 Hz length strobe
//   cpu_wram_req/addr, _gnt      : CPU wave-RAM access request and grant
//   wram_addr, wram_rd           : wave-RAM port address, channel fetch strobe
//   wram_rdata                   : wave-RAM data, valid the cycle after wram_rd
//   ch3_active                   : NR52 bit 2
//   dac_in                       : 4-bit sample to the channel-3 DAC
//
// Build option CH3_DMG_WRAM_QUIRK_EN: while running, the CPU only gets the
// port in the cycle after a fetch, and then sees the channel's current byte.
//
// state   | meaning
// --------+--------------------------------------------------------------
// CH3_OFF | channel silent, timer and position frozen
// CH3_RUN | timer counting up to 2047, fetching a nibble on each wrap
module ch3_wave_seq
    import ch3_pkg::*;
#(
    parameter int FREQ_W = 11,
    parameter int POS_W  = 5,
    parameter int LEN_W  = 9
) (
    input  logic              cery_2mhz,
    input  logic              napu_reset,
    input  logic              dac_en,
    input  logic              len_wr,
    input  logic [7:0]        len_data,
    input  logic              len_en,
    input  logic [FREQ_W-1:0] freq,
    input  logic              trig,
    input  logic [1:0]        vol_code,
    input  logic              len_tick,
    input  logic              cpu_wram_req,
    input  logic [3:0]        cpu_wram_addr,
    output logic              cpu_wram_gnt,
    output logic [3:0]        wram_addr,
    output logic              wram_rd,
    input  logic [7:0]        wram_rdata,
    output logic              ch3_active,
    output logic [3:0]        dac_in
);

    ch3_state_e        state;
    logic [FREQ_W-1:0] timer;
    logic [POS_W-1:0]  pos;
    logic              fetch_pend;
    logic              fetch_lo;
    logic [3:0]        sample_buf;
    logic              len_expire;
    logic [3:0]        chan_byte;

    ch3_len_ctr #(.LEN_W(LEN_W)) u_len_ctr (
        .cery_2mhz  (cery_2mhz),
        .napu_reset (napu_reset),
        .len_wr     (len_wr),
        .len_data   (len_data),
        .trig       (trig),
        .len_tick   (len_tick),
        .len_en     (len_en),
        .len_expire (len_expire)
    );

    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            state      <= CH3_OFF;
            timer      <= '0;
            pos        <= '0;
            wram_rd    <= 1'b0;
            fetch_pend <= 1'b0;
            fetch_lo   <= 1'b0;
            sample_buf <= 4'd0;
        end else begin
            wram_rd    <= 1'b0;
            fetch_pend <= wram_rd;
            // Nibble select is latched per fetch so back-to-back fetches
            // (period 1) each capture their own half of the byte.
            if (wram_rd)    fetch_lo   <= pos[0];
            if (fetch_pend) sample_buf <= fetch_lo ? wram_rdata[3:0] : wram_rdata[7:4];

            if (trig) begin
                state <= dac_en ? CH3_RUN : CH3_OFF;
                pos   <= '0;
                timer <= freq;
            end else if (state == CH3_RUN) begin
                if (!dac_en || len_expire) begin
                    state <= CH3_OFF;
                end else if (timer == FREQ_W'(CH3_TIMER_MAX)) begin
                    timer   <= freq;
                    pos     <= pos + 1'b1;
                    wram_rd <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

    assign chan_byte  = pos[POS_W-1:1];
    assign ch3_active = (state == CH3_RUN) && dac_en;
    assign dac_in     = ch3_active ? ch3_vol_shift(sample_buf, vol_code) : 4'd0;

`ifdef CH3_DMG_WRAM_QUIRK_EN
    assign cpu_wram_gnt = (state == CH3_RUN) ? (cpu_wram_req && fetch_pend)
                                             : (cpu_wram_req && !wram_rd);
    assign wram_addr    = (wram_rd || (cpu_wram_gnt && (state == CH3_RUN))) ? chan_byte
                        : (cpu_wram_gnt ? cpu_wram_addr : 4'd0);
`else
    assign cpu_wram_gnt = cpu_wram_req && !wram_rd;
    assign wram_addr    = wram_rd ? chan_byte : (cpu_wram_gnt ? cpu_wram_addr : 4'd0);
`endif

endmodule

// File: tb/tb_ch3_wave_seq.sv
`timescale 1ns/1ps
module tb_ch3_wave_seq;

    logic        cery_2mhz = 1'b0;
    logic        napu_reset = 1'b0;
    logic        dac_en = 1'b0;
    logic        len_wr = 1'b0;
    logic [7:0]  len_data = 8'd0;
    logic        len_en = 1'b0;
    logic [10:0] freq = 11'd0;
    logic        trig = 1'b0;
    logic [1:0]  vol_code = 2'd0;
    logic        len_tick = 1'b0;
    logic        cpu_wram_req = 1'b0;
    logic [3:0]  cpu_wram_addr = 4'd0;
    logic        cpu_wram_gnt;
    logic [3:0]  wram_addr;
    logic        wram_rd;
    logic [7:0]  wram_rdata = 8'd0;
    logic        ch3_active;
    logic [3:0]  dac_in;

    always #5 cery_2mhz = ~cery_2mhz;

    ch3_wave_seq dut (
        .cery_2mhz     (cery_2mhz),
        .napu_reset    (napu_reset),
        .dac_en        (dac_en),
        .len_wr        (len_wr),
        .len_data      (len_data),
        .len_en        (len_en),
        .freq          (freq),
        .trig          (trig),
        .vol_code      (vol_code),
        .len_tick      (len_tick),
        .cpu_wram_req  (cpu_wram_req),
        .cpu_wram_addr (cpu_wram_addr),
        .cpu_wram_gnt  (cpu_wram_gnt),
        .wram_addr     (wram_addr),
        .wram_rd       (wram_rd),
        .wram_rdata    (wram_rdata),
        .ch3_active    (ch3_active),
        .dac_in        (dac_in)
    );

    // Synchronous wave RAM: data appears the cycle after the fetch strobe.
    logic [7:0] wave [16];
    always @(posedge cery_2mhz) if (wram_rd) wram_rdata <= wave[wram_addr];

    int cyc = 0;
    always @(posedge cery_2mhz) cyc++;

    typedef struct { bit active; logic [3:0] dac; } stat_t;
    typedef struct { int cyc; bit cpu; logic [3:0] addr; } txn_t;
    typedef struct { int at; logic [3:0] val; } pend_t;

    stat_t stat_q[$];
    txn_t  txn_q[$];
    pend_t pend_q[$];

    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 0;

    // Reference model state: channel on, length left, trigger cycle and period.
    bit         m_on = 0;
    int         m_len = 0;
    int         m_tt = 0;
    int         m_per = 1;
    bit         m_adv_prev = 0;
    bit         m_fetch_prev = 0;
    int         m_pos = 0;
    logic [3:0] m_sample = 4'd0;
    bit         m_gnt_now = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] vshift(input logic [3:0] s, input logic [1:0] v);
        case (v)
            2'd0:    return 4'd0;
            2'd1:    return s;
            2'd2:    return 4'(s / 2);
            default: return 4'(s / 4);
        endcase
    endfunction

    // Fetch k (k>=1) of a run triggered in cycle T with period P strobes in
    // cycle T+1+k*P and reads position k mod 32; its nibble is visible 2 cycles later.
    task automatic model_cycle();
        stat_t s;
        txn_t  t;
        pend_t p;
        bit    fetch_now, gnt, expire, act;
        int    k;
        logic [3:0] gaddr;
        if (!napu_reset) begin
            m_on = 0; m_len = 0; m_sample = 4'd0; m_adv_prev = 0;
            m_fetch_prev = 0; m_pos = 0; m_gnt_now = 0;
            pend_q.delete();
            s.active = 0; s.dac = 4'd0;
            stat_q.push_back(s);
            return;
        end
        while (pend_q.size() > 0 && pend_q[0].at <= cyc) begin
            m_sample = pend_q[0].val;
            void'(pend_q.pop_front());
        end
        fetch_now = 0;
        if (m_adv_prev && ((cyc - m_tt - 1) % m_per == 0)) begin
            fetch_now = 1;
            k = (cyc - m_tt - 1) / m_per;
            m_pos = k % 32;
            t.cyc = cyc; t.cpu = 0; t.addr = 4'(m_pos / 2);
            txn_q.push_back(t);
            p.at = cyc + 2;
            p.val = (m_pos % 2 == 0) ? wave[m_pos / 2][7:4] : wave[m_pos / 2][3:0];
            pend_q.push_back(p);
        end
        act = m_on && dac_en;
        s.active = act;
        s.dac = act ? vshift(m_sample, vol_code) : 4'd0;
        stat_q.push_back(s);
`ifdef CH3_DMG_WRAM_QUIRK_EN
        if (m_on) begin
            gnt = cpu_wram_req && m_fetch_prev;
            gaddr = 4'(m_pos / 2);
        end else begin
            gnt = cpu_wram_req && !fetch_now;
            gaddr = cpu_wram_addr;
        end
`else
        gnt = cpu_wram_req && !fetch_now;
        gaddr = cpu_wram_addr;
`endif
        if (gnt) begin
            t.cyc = cyc; t.cpu = 1; t.addr = gaddr;
            txn_q.push_back(t);
        end
        m_gnt_now = gnt;
        m_fetch_prev = fetch_now;

        expire = !len_wr && !trig && len_tick && len_en && (m_len == 1);
        if (len_wr)                              m_len = 256 - int'(len_data);
        else if (trig)                           begin if (m_len == 0) m_len = 256; end
        else if (len_tick && len_en && m_len > 0) m_len = m_len - 1;
        m_adv_prev = m_on && dac_en && !expire && !trig;
        if (trig) begin
            m_on = dac_en; m_tt = cyc; m_per = 2048 - int'(freq); m_pos = 0;
        end else if (m_on && (!dac_en || expire)) begin
            m_on = 0;
        end
    endtask

    task automatic step();
        model_cycle();
        mon_en = 1;
        @(posedge cery_2mhz);
        #1;
        trig = 0; len_wr = 0; len_tick = 0;
        if (m_gnt_now) cpu_wram_req = 0;
    endtask

    task automatic maybe_cpu();
        if (!cpu_wram_req && $urandom_range(0, 3) == 0) begin
            cpu_wram_req = 1;
            cpu_wram_addr = 4'($urandom);
        end
    endtask

    task automatic pop_txn(input bit is_cpu);
        txn_t t;
        if (txn_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL port_access cyc=%0d got=unexpected %s exp=none", cyc, is_cpu ? "gnt" : "rd");
        end else begin
            t = txn_q.pop_front();
            chk(is_cpu ? "gnt_cycle" : "rd_cycle", cyc, t.cyc);
            chk(is_cpu ? "gnt_kind" : "rd_kind", 32'(is_cpu), 32'(t.cpu));
            chk(is_cpu ? "gnt_addr" : "rd_addr", wram_addr, t.addr);
        end
    endtask

    always @(negedge cery_2mhz) begin : monitor
        stat_t s;
        txn_t  t;
        if (mon_en) begin
            if (stat_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL status_queue cyc=%0d got=empty exp=entry", cyc);
            end else begin
                s = stat_q.pop_front();
                chk("ch3_active", ch3_active, s.active);
                chk("dac_in", dac_in, s.dac);
            end
            if (!napu_reset) chk("reset_wram_addr", wram_addr, 0);
            if (wram_rd)      pop_txn(0);
            if (cpu_wram_gnt) pop_txn(1);
            while (txn_q.size() > 0 && txn_q[0].cyc <= cyc) begin
                t = txn_q.pop_front();
                n_chk++; n_fail++;
                $display("FAIL missed_%s cyc=%0d got=none exp=addr %0h", t.cpu ? "gnt" : "rd", cyc, t.addr);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) wave[i] = 8'($urandom);
        wave[0] = 8'hA5;

        @(posedge cery_2mhz);
        #1;
        repeat (3) step();
        napu_reset = 1;
        step();

        // Steady run, period 4, CPU traffic, two volume settings.
        dac_en = 1; freq = 11'd2044; vol_code = 2'd1; trig = 1;
        step();
        repeat (140) begin maybe_cpu(); step(); end
        vol_code = 2'd3;
        repeat (140) begin maybe_cpu(); step(); end
        while (cpu_wram_req) step();

        // Length 2 expires on the second tick; third tick changes nothing.
        len_en = 1; len_wr = 1; len_data = 8'd254; step();
        trig = 1; step();
        repeat (5) step();
        len_tick = 1; step();
        repeat (5) step();
        len_tick = 1; step();
        repeat (3) step();
        len_tick = 1; step();
        repeat (3) step();

        // Trigger and tick together with one tick left: tick is dropped.
        len_wr = 1; len_data = 8'd255; step();
        trig = 1; len_tick = 1; step();
        repeat (4) step();
        len_tick = 1; step();
        repeat (3) step();
        trig = 1; step();
        repeat (6) step();
        dac_en = 0; step();
        step();
        dac_en = 1;
        repeat (3) step();

        // Period 1: fetch every cycle, position wraps twice.
        len_en = 0; freq = 11'd2047; vol_code = 2'd2; trig = 1;
        step();
        repeat (70) begin maybe_cpu(); step(); end
        cpu_wram_req = 0;
        napu_reset = 0;
        step();
        step();
        napu_reset = 1;
        step();

        // Randomized traffic.
        repeat (4000) begin
            if ($urandom_range(0, 99) < 3) begin
                trig = 1;
                freq = 11'(2048 - $urandom_range(1, 12));
            end
            if ($urandom_range(0, 99) < 4) len_tick = 1;
            if ($urandom_range(0, 99) < 2) begin
                len_wr = 1;
                len_data = 8'($urandom_range(236, 255));
            end
            if ($urandom_range(0, 99) < 2) dac_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 99) < 2) len_en = ~len_en;
            if ($urandom_range(0, 99) < 3) vol_code = 2'($urandom);
            maybe_cpu();
            step();
        end
        mon_en = 0;
        chk("txn_queue_drained", txn_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ch3_wave_seq.md
Name: ch3_wave_seq

Overview:
- Sequencer and wave-RAM arbiter for sound channel 3 (wave channel), driven by the ch3 register file outputs (NR30–NR34 decode).
- Runs the 11-bit frequency timer, 5-bit sample position, 256-step length counter and on/off state.
- Fetches wave-RAM bytes and shares the single wave-RAM port between the channel and CPU.
- Produces the volume-shifted 4-bit sample for the channel-3 DAC and the channel-active flag for NR52.

Parameters:
FREQ_W, 11, frequency timer / NR33-NR34 frequency width
POS_W, 5, sample position width (32 nibbles)
LEN_W, 9, length remaining width (0..256)

Ports:
cery_2mhz  input  1  APU 2 MHz clock; all state on rising edge
napu_reset  input  1  asynchronous active-low reset
dac_en  input  1  NR30 bit 7
len_wr  input  1  one-cycle strobe, NR31 written
len_data  input  8  NR31 value
len_en  input  1  NR34 bit 6
freq  input  11  NR34[2:0]:NR33
trig  input  1  one-cycle strobe, NR34 written with bit 7 set
vol_code  input  2  NR32[6:5]
len_tick  input  1  one-cycle 256 Hz frame-sequencer strobe
cpu_wram_req  input  1  CPU wave-RAM access request (FF30-FF3F)
cpu_wram_addr  input  4  CPU byte address
cpu_wram_gnt  output  1  CPU access granted this cycle
wram_addr  output  4  wave-RAM port address
wram_rd  output  1  channel fetch strobe
wram_rdata  input  8  wave-RAM read data, valid cycle after wram_rd
ch3_active  output  1  channel on (NR52 bit 2)
dac_in  output  4  shifted sample to DAC

Behaviour:
- Reset: state OFF, timer 0, pos 0, len_rem 0, sample_buf 0, all outputs 0.
- States: OFF, RUN.
  - OFF->RUN on trig with dac_en=1.
  - RUN->OFF when dac_en=0 (same cycle, combinational gate on ch3_active), or on length expiry.
  - trig with dac_en=0: stays/goes OFF, length still reloaded.
- Trigger:
  - pos <= 0; timer <= freq.
  - If len_rem==0, len_rem <= 256.
  - sample_buf unchanged.
- Timer, in RUN only:
  - timer increments each clock.
  - At timer==2047: next cycle timer <= freq, pos <= pos+1 (31 wraps to 0), wram_rd pulses for one cycle.
  - Period is exactly 2048-freq cycles; freq=2047 gives period 1.
  - freq changes take effect at next reload only.
- Fetch:
  - wram_addr = pos[4:1] during the wram_rd cycle.
  - Next cycle, sample_buf <= pos[0]==0 ? wram_rdata[7:4] : wram_rdata[3:0].
- Arbitration: channel fetch has priority.
  - cpu_wram_gnt = cpu_wram_req && !wram_rd.
  - In grant cycles, wram_addr = cpu_wram_addr.
  - A denied CPU request must be held; it is granted the following cycle. Back-to-back fetches are impossible except at freq=2047.
- Length:
  - len_wr: len_rem <= 256-len_data.
  - len_tick with len_en=1 and len_rem!=0: decrement. Reaching 0 forces OFF that cycle.
  - Ticks are honoured in OFF as well.
- Simultaneous events:
  - trig and len_tick: trig wins, tick dropped.
  - len_wr and len_tick: write wins.
  - trig and timer reload: trig wins.
- dac_in by vol_code:
  - 00 -> 0
  - 01 -> sample_buf
  - 10 -> sample_buf>>1
  - 11 -> sample_buf>>2
  - Output is 0 whenever ch3_active=0.
- Reset mid-fetch discards pending sample capture.

Optional Feature:
- Macro: CH3_DMG_WRAM_QUIRK_EN.
- Defined:
  - While RUN, a CPU request is granted only in the cycle after wram_rd.
  - In that cycle, wram_addr is forced to the channel's current byte (pos[4:1]), not cpu_wram_addr.
  - Requests in other RUN cycles are held ungranted.
- Undefined: plain priority arbitration as above.

Decomposition:
- Package ch3_pkg holds:
  - state enum ch3_state_e {CH3_OFF, CH3_RUN}
  - volume enum ch3_vol_e
  - constants CH3_TIMER_MAX=2047, CH3_LEN_FULL=256
- Sub-module ch3_len_ctr: len_rem load/reload/decrement plus expiry pulse.

Test Plan:
- Reset, then dac_en=1, freq=2044, trig -> ch3_active=1; wram_rd every 4 cycles; wram_addr 0,1,1,2... matching pos 1,2,3,4.
- RAM byte0=0xA5, vol_code=01 -> dac_in=0xA at pos 0, 0x5 at pos 1; vol_code=11 -> 0x2 then 0x1.
- len_data=254, len_en=1, trig, 2 len_ticks -> ch3_active falls on second tick; third tick no effect.
- cpu_wram_req held during fetch cycle -> gnt=0 that cycle, gnt=1 next with wram_addr=cpu_wram_addr.
- trig and len_tick same cycle with len_rem=1 -> channel stays on, len_rem=1; dac_en=0 mid-run -> ch3_active=0 same cycle.
- freq=2047 for 64 cycles -> pos wraps 31->0 twice; napu_reset low mid-run -> all outputs 0 immediately.
